fifo_ctrl_sync: RTL and testbench
=================================

Name: fifo_ctrl_sync

Overview:
- Single-clock FIFO controller that drives the write and read address ports of the distributed simple-dual-port RAM. The RAM is instantiated with OUT_REG=0, and its wr_clk and rd_clk are tied to clk.
- Generates RAM write enable and write/read addresses, an occupancy count, status flags and error pulses.
- Presents first-word-fall-through semantics: the head word is always visible on the RAM read data whenever empty=0.
- Sits between a streaming producer and consumer; the RAM data path passes around this block.

Parameters:
- ADDR_WIDTH, 4, RAM address width (4-10). Depth = 2**ADDR_WIDTH.
- AF_THRESH, 2**ADDR_WIDTH-2, almost_full asserted when count >= AF_THRESH.
- AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH.

Ports:
- clk  in  1  single clock for controller and RAM.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous flush; empties the FIFO.
- wr_en  in  1  producer write request.
- rd_en  in  1  consumer read request; pops the head word.
- ram_wr_en  out  1  to RAM wr_en.
- ram_wr_addr  out  ADDR_WIDTH  to RAM wr_addr.
- ram_rd_addr  out  ADDR_WIDTH  to RAM rd_addr.
- full  out  1  registered.
- empty  out  1  registered.
- almost_full  out  1  registered.
- almost_empty  out  1  registered.
- count  out  ADDR_WIDTH+1  registered occupancy, 0..2**ADDR_WIDTH.
- overflow  out  1  one-cycle pulse on a rejected write.
- underflow  out  1  one-cycle pulse on a rejected read.

Behaviour:
- Reset (rst_n low, async): wr_ptr=0, rd_ptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, ready=0.
- ready register: goes to 1 on the first clk edge after rst_n rises.
- Pointers: wr_ptr and rd_ptr are ADDR_WIDTH+1 bits; the MSB is a wrap bit.
  - ram_wr_addr = wr_ptr[ADDR_WIDTH-1:0].
  - ram_rd_addr = rd_ptr[ADDR_WIDTH-1:0].
  - Both increment modulo 2**(ADDR_WIDTH+1).
- Accept rules (combinational, all qualified by ready):
  - wa = wr_en & ~full & ~clr & ready.
  - ra = rd_en & ~empty & ~clr & ready.
- ram_wr_en = wa. The RAM captures data at the same edge that advances wr_ptr.
- Write latency: a word written at edge t is visible on RAM rd_data after edge t if it is the head. empty falls at edge t, so the first word is visible 1 cycle after wr_en.
- Read: the head is valid combinationally while empty=0. The consumer samples data with rd_en in the same cycle; rd_ptr advances at the edge.
- count update per edge:
  - wa&~ra: +1.
  - ra&~wa: -1.
  - both or neither: unchanged.
- Flags are registered from next-count:
  - full = (next==2**ADDR_WIDTH).
  - empty = (next==0).
  - almost_full = (next>=AF_THRESH).
  - almost_empty = (next<=AE_THRESH).
- Simultaneous events:
  - Empty with wr_en & rd_en: write accepted, read rejected, underflow pulses.
  - Full with wr_en & rd_en: read accepted, write rejected, overflow pulses. count drops to depth-1 and full clears next cycle.
  - Neither full nor empty: both accepted, count unchanged, both pointers advance.
- overflow (registered) = wr_en & full & ready & ~clr, seen at the previous edge. underflow likewise with rd_en & empty.
- clr: at the edge, pointers and count go to 0 and flags take their reset values. clr has priority over wr_en/rd_en; no RAM write occurs and no error pulses are raised.
- Wrap-around: pointers roll over seamlessly. Full/empty derive from count, which must agree with (wr_ptr - rd_ptr).
- Reset mid-operation: contents are discarded and all outputs immediately take reset values. RAM contents are not cleared.

Decomposition:
- Shared package:
  - Function fifo_depth(ADDR_WIDTH) = 2**ADDR_WIDTH.
  - Localparam PTR_W = ADDR_WIDTH+1.
  - Default threshold constants.
- No sub-module inside the controller.
- A separate wrapper fifo_sync_top instantiates fifo_ctrl_sync plus the distributed SDPRAM (OUT_REG=0) and exposes wr_data/rd_data.

Test Plan (ADDR_WIDTH=4, depth 16):
- Reset then idle → empty=1, almost_empty=1, count=0, full=0, ram_wr_addr=0, ram_rd_addr=0; wr_en during the first cycle after release is ignored.
- Write 0x0..0xF back-to-back → count reaches 16, full=1 after the 16th edge, almost_full=1 from count 14. A 17th wr_en gives overflow=1 for exactly one cycle, count stays 16, ram_wr_en=0.
- Drain 16 words → rd_data sequence 0x0..0xF. empty=1 after the 16th pop; an extra rd_en gives underflow one-cycle pulse.
- Simultaneous wr/rd at count=8 for 40 cycles → count stays 8, pointers wrap twice (ram addresses 0..15 repeating), data order preserved.
- Empty + wr_en&rd_en → count=1, underflow=1. Full + wr_en&rd_en → count=15, overflow=1, full=0.
- clr at count=10 together with wr_en → count=0, empty=1, no RAM write, no error pulse. Assert rst_n low mid-burst → flags reset asynchronously.

Source files
------------

// File: rtl/fifo_ctrl_sync_pkg.sv
// Shared definitions for the single-clock FIFO controller: depth helper,
// pointer width and default flag thresholds.
package fifo_ctrl_sync_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 4;
    localparam int PTR_W              = DEFAULT_ADDR_WIDTH + 1;
    localparam int DEFAULT_AE_THRESH  = 2;
    localparam int DEFAULT_AF_MARGIN  = 2;

    // Number of words held by a RAM with the given address width.
    function automatic int fifo_depth(input int addr_width);
        return 32'sd1 <<< addr_width;
    endfunction

endpackage : fifo_ctrl_sync_pkg

// File: rtl/fifo_ctrl_sync.sv
// Single-clock FIFO controller for a distributed simple-dual-port RAM with an
// unregistered read port. The head word is visible on the RAM read data
// whenever empty is low (first-word-fall-through). Occupancy is tracked with
// an explicit counter; flags are registered from the next count value.
module fifo_ctrl_sync
    import fifo_ctrl_sync_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int AF_THRESH  = fifo_depth(ADDR_WIDTH) - DEFAULT_AF_MARGIN,
    parameter int AE_THRESH  = DEFAULT_AE_THRESH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int CW = ADDR_WIDTH + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(fifo_depth(ADDR_WIDTH));
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [CW-1:0] ZERO_C  = CW'(0);

    logic [CW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          full_q,   full_d;
    logic          empty_q,  empty_d;
    logic          af_q,     af_d;
    logic          ae_q,     ae_d;
    logic          ovf_q,    ovf_d;
    logic          udf_q,    udf_d;
    logic          ready_q,  ready_d;
    logic          wa_s;
    logic          ra_s;

    // Accept qualification and next-state computation for pointers, count and flags.
    always_comb begin
        wa_s     = wr_en & ~full_q  & ~clr & ready_q;
        ra_s     = rd_en & ~empty_q & ~clr & ready_q;
        ready_d  = 1'b1;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (clr) begin
            wr_ptr_d = ZERO_C;
            rd_ptr_d = ZERO_C;
            count_d  = ZERO_C;
        end else begin
            if (wa_s) begin
                wr_ptr_d = wr_ptr_q + ONE_C;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (ra_s) begin
                rd_ptr_d = rd_ptr_q + ONE_C;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({wa_s, ra_s})
                2'b10:   count_d = count_q + ONE_C;
                2'b01:   count_d = count_q - ONE_C;
                default: count_d = count_q;
            endcase
        end

        // A zero count gives the reset flag values, so clr needs no special case here.
        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == ZERO_C);
        af_d    = (count_d >= AF_C);
        ae_d    = (count_d <= AE_C);

        // Error pulses report requests that were refused only because of full/empty.
        ovf_d = wr_en & full_q  & ready_q & ~clr;
        udf_d = rd_en & empty_q & ready_q & ~clr;
    end

    // State register with asynchronous reset to the empty, not-ready state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= ZERO_C;
            rd_ptr_q <= ZERO_C;
            count_q  <= ZERO_C;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            ready_q  <= ready_d;
        end
    end

    // The RAM write strobe must be combinational so the word lands on the
    // same edge that advances the write pointer.
    assign ram_wr_en    = wa_s;
    assign ram_wr_addr  = wr_ptr_q[ADDR_WIDTH-1:0];
    assign ram_rd_addr  = rd_ptr_q[ADDR_WIDTH-1:0];
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule : fifo_ctrl_sync

// File: tb/tb_fifo_ctrl_sync.sv
// Directed bench for fifo_ctrl_sync (ADDR_WIDTH=4). A small behavioural RAM
// with an asynchronous read port stands in for the distributed SDPRAM so that
// first-word-fall-through data ordering can be observed.
module tb_fifo_ctrl_sync;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       wr_en;
    logic       rd_en;
    logic       ram_wr_en;
    logic [3:0] ram_wr_addr;
    logic [3:0] ram_rd_addr;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    logic [7:0] wdata;
    logic [7:0] rd_data;
    logic [7:0] mem [0:15];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fifo_ctrl_sync #(.ADDR_WIDTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .ram_wr_en    (ram_wr_en),
        .ram_wr_addr  (ram_wr_addr),
        .ram_rd_addr  (ram_rd_addr),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    // Behavioural RAM: synchronous write, asynchronous read.
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= wdata;
    end
    assign rd_data = mem[ram_rd_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        clr   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        wdata = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_empty",   32'(empty),        32'd1);
        check("rst_ae",      32'(almost_empty), 32'd1);
        check("rst_count",   32'(count),        32'd0);
        check("rst_full",    32'(full),         32'd0);
        check("rst_af",      32'(almost_full),  32'd0);
        check("rst_wraddr",  32'(ram_wr_addr),  32'd0);
        check("rst_rdaddr",  32'(ram_rd_addr),  32'd0);
        check("rst_ovf",     32'(overflow),     32'd0);

        // Release with wr_en already high: first cycle is not ready
        rst_n = 1'b1;
        wr_en = 1'b1;
        wdata = 8'h00;
        check("notready_wren", 32'(ram_wr_en), 32'd0);
        step();
        check("notready_count", 32'(count), 32'd0);
        check("notready_empty", 32'(empty), 32'd1);

        // Fill 0x0..0xF
        for (int i = 0; i < 16; i++) begin
            wdata = 8'(i);
            check("fill_wren", 32'(ram_wr_en), 32'd1);
            step();
            check("fill_count", 32'(count),       32'(i + 1));
            check("fill_af",    32'(almost_full), 32'((i + 1) >= 14));
            check("fill_full",  32'(full),        32'((i + 1) == 16));
            check("fill_empty", 32'(empty),       32'd0);
            if (i == 0) check("fwft_first", 32'(rd_data), 32'h00);
        end

        // 17th write is rejected
        wdata = 8'hEE;
        check("ovf_wren", 32'(ram_wr_en), 32'd0);
        step();
        check("ovf_pulse", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count),    32'd16);
        wr_en = 1'b0;
        step();
        check("ovf_clear", 32'(overflow), 32'd0);

        // Drain 16 words in order
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("drain_data", 32'(rd_data), 32'(i));
            step();
            check("drain_count", 32'(count),        32'(15 - i));
            check("drain_ae",    32'(almost_empty), 32'((15 - i) <= 2));
        end
        check("drain_empty", 32'(empty), 32'd1);
        step();
        check("udf_pulse", 32'(underflow), 32'd1);
        check("udf_count", 32'(count),     32'd0);
        rd_en = 1'b0;
        step();
        check("udf_clear", 32'(underflow), 32'd0);

        // Prefill 8 words, then 40 cycles of simultaneous write/read
        wr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wdata = 8'(8'h20 + i);
            step();
        end
        check("pre_count", 32'(count), 32'd8);
        rd_en = 1'b1;
        for (int c = 0; c < 40; c++) begin
            wdata = 8'(8'h28 + c);
            check("sim_data",   32'(rd_data),     32'(8'h20 + c));
            check("sim_wraddr", 32'(ram_wr_addr), 32'((8 + c) % 16));
            check("sim_rdaddr", 32'(ram_rd_addr), 32'(c % 16));
            step();
            check("sim_count",  32'(count),       32'd8);
        end
        wr_en = 1'b0;
        for (int j = 0; j < 8; j++) begin
            check("sim_tail", 32'(rd_data), 32'(8'h48 + j));
            step();
        end
        check("sim_empty", 32'(empty), 32'd1);
        rd_en = 1'b0;

        // Empty with simultaneous write and read
        wr_en = 1'b1;
        rd_en = 1'b1;
        wdata = 8'hA5;
        step();
        check("ewr_count", 32'(count),     32'd1);
        check("ewr_udf",   32'(underflow), 32'd1);
        check("ewr_data",  32'(rd_data),   32'hA5);
        rd_en = 1'b0;
        for (int i = 0; i < 15; i++) begin
            wdata = 8'(8'hB0 + i);
            step();
        end
        check("fwr_full_pre", 32'(full), 32'd1);

        // Full with simultaneous write and read
        rd_en = 1'b1;
        wdata = 8'hCC;
        step();
        check("fwr_count", 32'(count),    32'd15);
        check("fwr_ovf",   32'(overflow), 32'd1);
        check("fwr_full",  32'(full),     32'd0);
        check("fwr_head",  32'(rd_data),  32'hB0);
        wr_en = 1'b0;

        // Bring count to 10, then clr together with wr_en
        for (int i = 0; i < 5; i++) step();
        rd_en = 1'b0;
        check("pre_clr_count", 32'(count), 32'd10);
        clr   = 1'b1;
        wr_en = 1'b1;
        check("clr_wren", 32'(ram_wr_en), 32'd0);
        step();
        check("clr_count", 32'(count),       32'd0);
        check("clr_empty", 32'(empty),       32'd1);
        check("clr_ae",    32'(almost_empty), 32'd1);
        check("clr_ovf",   32'(overflow),    32'd0);
        check("clr_udf",   32'(underflow),   32'd0);
        check("clr_wraddr", 32'(ram_wr_addr), 32'd0);
        check("clr_rdaddr", 32'(ram_rd_addr), 32'd0);
        clr = 1'b0;

        // Asynchronous reset mid-burst
        for (int i = 0; i < 3; i++) begin
            wdata = 8'(8'hD0 + i);
            step();
        end
        check("burst_count", 32'(count), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_count",  32'(count),       32'd0);
        check("arst_empty",  32'(empty),       32'd1);
        check("arst_ae",     32'(almost_empty), 32'd1);
        check("arst_wraddr", 32'(ram_wr_addr), 32'd0);
        check("arst_wren",   32'(ram_wr_en),   32'd0);
        wr_en = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fifo_ctrl_sync
